// File: rtl/lfsr_prbs_checker.sv
// lfsr_prbs_checker: serial PRBS checker for the 4-bit lfsr generator.
// It self-synchronises to the incoming stream, locks after LOCK_CNT correct
// predictions, counts mismatches while locked and drops lock after LOSS_CNT
// consecutive mismatches.
// Optional macro PRBS_FLYWHEEL_EN: while locked, the history register
// free-runs on its own prediction, so a single flipped input bit costs
// exactly one error. Without it, the history always takes the received bit.
module lfsr_prbs_checker #(
  parameter int              WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS    = 4'b1100,
  parameter int              LOCK_CNT = 8,
  parameter int              LOSS_CNT = 4,
  parameter int              ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int               FILL_W    = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       LOSS_LAST = 8'(LOSS_CNT - 1);

  state_t            state_reg;
  logic [WIDTH-1:0]  h_reg;
  logic [WIDTH-1:0]  h_next;
  logic [FILL_W-1:0] fill_reg;
  logic [7:0]        run_reg;
  logic [7:0]        bad_reg;

  logic [WIDTH-1:0]  tap_bits;
  logic              pred;
  logic              match;
  logic              h_zero;
  logic              nb;

  // Prediction is the parity of the tapped history bits.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tap_bits[gi] = h_reg[gi] & TAPS[gi];
  end

  assign pred   = ^tap_bits;
  assign match  = (din == pred);
  assign h_zero = (h_reg == '0);
  assign h_next = {h_reg[WIDTH-2:0], nb};

  // Select the bit shifted into history: received bit, or the local prediction when flywheeling in lock.
  always_comb begin
    nb = din;
`ifdef PRBS_FLYWHEEL_EN
    if (state_reg == LOCKED) begin
      nb = pred;
    end
`endif
  end

  // Sync FSM, history shift, lock/loss counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= SEARCH;
      h_reg     <= '0;
      fill_reg  <= '0;
      run_reg   <= '0;
      bad_reg   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        h_reg <= h_next;
        case (state_reg)
          SEARCH: begin
            fill_reg <= fill_reg + 1'b1;
            if (fill_reg == FILL_LAST) begin
              state_reg <= VERIFY;
              run_reg   <= '0;
            end
          end
          VERIFY: begin
            // An all-zero history is the degenerate stream and never builds toward lock.
            if (match && !h_zero) begin
              run_reg <= run_reg + 8'd1;
              if (run_reg == LOCK_LAST) begin
                state_reg <= LOCKED;
                locked    <= 1'b1;
                bad_reg   <= '0;
              end
            end else begin
              run_reg <= '0;
            end
          end
          LOCKED: begin
            if (!match) begin
              err_pulse <= 1'b1;
              bad_reg   <= bad_reg + 8'd1;
              if (bad_reg == LOSS_LAST) begin
                state_reg <= SEARCH;
                locked    <= 1'b0;
                fill_reg  <= '0;
              end
            end else begin
              bad_reg <= '0;
            end
          end
          default: begin
            state_reg <= SEARCH;
            locked    <= 1'b0;
            fill_reg  <= '0;
          end
        endcase
      end
      // Clear beats a simultaneous increment; the count saturates at all-ones.
      if (clr_cnt) begin
        err_count <= '0;
      end else if (din_valid && (state_reg == LOCKED) && !match && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb_lfsr_prbs_checker: directed and randomised checks of lfsr_prbs_checker
// against a rule-level reference model (history kept as a bit queue).
// A second instance with ERR_W=2 shares all inputs to exercise saturation.
module tb_lfsr_prbs_checker;

  localparam int       WIDTH = 4;
  localparam int       LOCK  = 8;
  localparam int       LOSS  = 4;
  localparam bit [3:0] TAPS  = 4'b1100;
`ifdef PRBS_FLYWHEEL_EN
  localparam bit FLYWHEEL = 1'b1;
`else
  localparam bit FLYWHEEL = 1'b0;
`endif
  localparam int FLIP_ERRS = FLYWHEEL ? 1 : 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din;
  logic        clr_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic        locked_s;
  logic        err_pulse_s;
  logic [1:0]  err_count_s;

  always #5 clk = ~clk;

  lfsr_prbs_checker u_dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  lfsr_prbs_checker #(.ERR_W(2)) u_sat (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s)
  );

  int total = 0;
  int bad   = 0;

  bit pattern [15] = '{1,0,0,0,1,0,0,1,1,0,1,0,1,1,1};
  int sidx = 0;

  // reference model state: 0 searching, 1 verifying, 2 locked
  int m_state;
  int m_fill;
  int m_run;
  int m_bad;
  bit m_hist[$];
  int m_cnt;
  int m_cnt2;
  bit m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_pred();
    bit r = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (TAPS[i]) r ^= m_hist[m_hist.size() - 1 - i];
    end
    return r;
  endfunction

  task automatic m_reset();
    m_state = 0;
    m_fill  = 0;
    m_run   = 0;
    m_bad   = 0;
    m_hist  = {};
    for (int i = 0; i < WIDTH; i++) m_hist.push_back(1'b0);
    m_cnt   = 0;
    m_cnt2  = 0;
    m_pulse = 1'b0;
  endtask

  task automatic m_step(input bit v, input bit d, input bit c);
    bit p;
    bit mt;
    bit z;
    bit nb;
    m_pulse = 1'b0;
    if (v) begin
      p  = m_pred();
      mt = (d == p);
      z  = 1'b1;
      foreach (m_hist[i]) if (m_hist[i]) z = 1'b0;
      nb = d;
      if (m_state == 0) begin
        m_fill++;
        if (m_fill == WIDTH) begin
          m_state = 1;
          m_run   = 0;
        end
      end else if (m_state == 1) begin
        if (mt && !z) begin
          m_run++;
          if (m_run == LOCK) begin
            m_state = 2;
            m_bad   = 0;
          end
        end else begin
          m_run = 0;
        end
      end else begin
        if (FLYWHEEL) nb = p;
        if (!mt) begin
          m_pulse = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
          m_bad++;
          if (m_bad == LOSS) begin
            m_state = 0;
            m_fill  = 0;
          end
        end else begin
          m_bad = 0;
        end
      end
      m_hist.push_back(nb);
      void'(m_hist.pop_front());
    end
    if (c) begin
      m_cnt  = 0;
      m_cnt2 = 0;
    end
  endtask

  task automatic cycle(input bit v, input bit d, input bit c);
    @(negedge clk);
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    @(posedge clk);
    #1;
    m_step(v, d, c);
    check("locked", locked, m_state == 2);
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, m_cnt);
    check("sat_count", err_count_s, m_cnt2);
    $display("cyc t=%0t v=%0b din=%0b clr=%0b locked=%0b pulse=%0b cnt=%0d sat=%0d",
             $time, v, d, c, locked, err_pulse, err_count, err_count_s);
  endtask

  task automatic clean_bit();
    cycle(1'b1, pattern[sidx % 15], 1'b0);
    sidx++;
  endtask

  task automatic flip_bit();
    cycle(1'b1, !pattern[sidx % 15], 1'b0);
    sidx++;
  endtask

  task automatic force_miss(input bit c);
    cycle(1'b1, !m_pred(), c);
    sidx++;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    din_valid = 1'b0;
    clr_cnt   = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_pulse"}, err_pulse, 1'b0);
    check({tag, "_count"}, err_count, 16'd0);
    check({tag, "_sat"}, err_count_s, 2'd0);
    @(negedge clk);
    rst  = 1'b0;
    sidx = 0;
  endtask

  initial begin
    int  npulse;
    bit  p30;
    bit  p33;
    bit  p34;
    bit  lost;
    bit  ever;
    bit  v;
    bit  f;
    bit  c;

    // reset from time zero
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
    clr_cnt   = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst0_locked", locked, 1'b0);
    check("rst0_pulse", err_pulse, 1'b0);
    check("rst0_count", err_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // clean lock over 60 bits
    npulse = 0;
    for (int k = 1; k <= 60; k++) begin
      clean_bit();
      if (err_pulse) npulse++;
      if (k == 11) check("lock_bit11", locked, 1'b0);
      if (k == 12) check("lock_bit12", locked, 1'b1);
    end
    check("clean_pulses", npulse, 0);
    check("clean_count", err_count, 16'd0);

    // single flipped bit while locked
    npulse = 0; p30 = 0; p33 = 0; p34 = 0; lost = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 30) flip_bit(); else clean_bit();
      if (!locked) lost = 1'b1;
      if (err_pulse) begin
        npulse++;
        if (k == 30) p30 = 1'b1;
        if (k == 33) p33 = 1'b1;
        if (k == 34) p34 = 1'b1;
      end
    end
    check("flip_p30", p30, 1'b1);
    check("flip_p33", p33, !FLYWHEEL);
    check("flip_p34", p34, !FLYWHEEL);
    check("flip_pulses", npulse, FLIP_ERRS);
    check("flip_count", err_count, FLIP_ERRS);
    check("flip_lost", lost, 1'b0);

    // asynchronous reset in mid-lock, then relock
    do_reset("rst_mid");
    for (int k = 1; k <= 12; k++) begin
      clean_bit();
      if (k == 11) check("relock_bit11", locked, 1'b0);
      if (k == 12) check("relock_bit12", locked, 1'b1);
    end

    // four consecutive mismatches drop lock
    for (int k = 1; k <= 4; k++) begin
      force_miss(1'b0);
      if (k < 4) check("loss_hold", locked, 1'b1);
      else       check("loss_drop", locked, 1'b0);
    end
    check("loss_count", err_count, 16'd4);
    check("loss_sat", err_count_s, 2'd3);
    for (int k = 1; k <= 12; k++) begin
      clean_bit();
      if (k == 11) check("loss_relock11", locked, 1'b0);
      if (k == 12) check("loss_relock12", locked, 1'b1);
    end

    // zero stream never locks
    do_reset("rst_zero");
    ever = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      if (locked) ever = 1'b1;
    end
    check("zero_never_lock", ever, 1'b0);

    // gapped clean stream locks after 12 valid bits
    do_reset("rst_gap");
    for (int k = 1; k <= 12; k++) begin
      clean_bit();
      if (k == 11) check("gap_lock11", locked, 1'b0);
      if (k == 12) check("gap_lock12", locked, 1'b1);
      cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // clear coinciding with a locked mismatch
    force_miss(1'b0);
    for (int k = 1; k <= 10; k++) clean_bit();
    check("pre_clr_count", err_count, FLIP_ERRS);
    force_miss(1'b1);
    check("clr_count", err_count, 16'd0);
    check("clr_pulse", err_pulse, 1'b1);
    check("clr_locked", locked, 1'b1);
    for (int k = 1; k <= 10; k++) clean_bit();
    cycle(1'b0, 1'b0, 1'b1);

    // five isolated errors saturate the 2-bit counter
    for (int e = 0; e < 5; e++) begin
      flip_bit();
      for (int k = 1; k <= 19; k++) clean_bit();
    end
    check("sat_hold", err_count_s, 2'd3);
    check("sat_main", err_count, 5 * FLIP_ERRS);

    // randomised gaps, flips and clears
    for (int k = 0; k < 400; k++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 79) == 0);
      cycle(v, pattern[sidx % 15] ^ f, c);
      if (v) sidx++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
